wb_mem_tester: RTL and testbench

Wishbone pipelined master that drives a single-cycle-ack memory slave (16-bit data, 8-bit address by default) directly upstream of it. On start it writes a seed-derived pattern to every address, reads every address back, compares, and reports pass/fail, error count and first failing address. It is the built-in self-test stage for the memory and the stimulus source for system-level formal and simulation runs.

---
 rtl/wb_mem_tester.sv | 192 +++++++++++++++++++
 tb/tb_wb_mem_tester.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_tester.sv
// Wishbone pipelined BIST master: writes seed+addr everywhere, reads it back and reports mismatches.
// Two cycles per access with an ideal slave; a stall holds the request, a missing ack aborts after G_TIMEOUT cycles.
module wb_mem_tester #(
  parameter int G_ADDR_SIZE = 8,
  parameter int G_DATA_SIZE = 16,
  parameter int G_TIMEOUT   = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [G_DATA_SIZE-1:0] seed_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   timeout_o,
  output logic [G_ADDR_SIZE:0]   err_count_o,
  output logic [G_ADDR_SIZE-1:0] err_addr_o,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  input  logic                   wb_stall_i,
  input  logic                   wb_ack_i,
  output logic                   wb_we_o,
  output logic [G_ADDR_SIZE-1:0] wb_addr_o,
  output logic [G_DATA_SIZE-1:0] wb_data_o,
  input  logic [G_DATA_SIZE-1:0] wb_data_i
);

  localparam int TW = $clog2(G_TIMEOUT + 1);
  localparam logic [G_ADDR_SIZE:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_ACK = 3'd2,
    RD_REQ = 3'd3,
    RD_ACK = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [G_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [G_DATA_SIZE-1:0] seed_q, seed_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   error_q, error_d;
  logic                   timeout_q, timeout_d;
  logic [G_ADDR_SIZE:0]   err_count_q, err_count_d;
  logic [G_ADDR_SIZE-1:0] err_addr_q, err_addr_d;

  logic [G_DATA_SIZE-1:0] pattern;
  logic                   addr_last;
  logic                   ack_expired;

  assign pattern     = seed_q + G_DATA_SIZE'(addr_q);
  assign addr_last   = &addr_q;
  assign ack_expired = (tmo_q == TW'(G_TIMEOUT - 1));

  assign error_o     = error_q;
  assign timeout_o   = timeout_q;
  assign err_count_o = err_count_q;
  assign err_addr_o  = err_addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      seed_q      <= '0;
      tmo_q       <= '0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      tmo_q       <= tmo_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    seed_d      = seed_q;
    tmo_d       = tmo_q;
    error_d     = error_q;
    timeout_d   = timeout_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_addr_o   = '0;
    wb_data_o   = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          seed_d      = seed_i;
          addr_d      = '0;
          error_d     = 1'b0;
          timeout_d   = 1'b0;
          err_count_d = '0;
          err_addr_d  = '0;
          state_d     = WR_REQ;
        end
      end

      WR_REQ: begin
        busy_o    = 1'b1;
        wb_cyc_o  = 1'b1;
        wb_stb_o  = 1'b1;
        wb_we_o   = 1'b1;
        wb_addr_o = addr_q;
        wb_data_o = pattern;
        if (!wb_stall_i) begin
          tmo_d   = '0;
          state_d = WR_ACK;
        end
      end

      WR_ACK: begin
        busy_o    = 1'b1;
        wb_cyc_o  = 1'b1;
        wb_we_o   = 1'b1;
        wb_addr_o = addr_q;
        wb_data_o = pattern;
        if (wb_ack_i) begin
          addr_d  = addr_q + G_ADDR_SIZE'(1);
          state_d = addr_last ? RD_REQ : WR_REQ;
        end else if (ack_expired) begin
          error_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = FINISH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      RD_REQ: begin
        busy_o    = 1'b1;
        wb_cyc_o  = 1'b1;
        wb_stb_o  = 1'b1;
        wb_addr_o = addr_q;
        if (!wb_stall_i) begin
          tmo_d   = '0;
          state_d = RD_ACK;
        end
      end

      RD_ACK: begin
        busy_o    = 1'b1;
        wb_cyc_o  = 1'b1;
        wb_addr_o = addr_q;
        if (wb_ack_i) begin
          // Only mismatches bump the count, so a zero count marks the first one of the run.
          if (wb_data_i != pattern) begin
            error_d = 1'b1;
            if (err_count_q == '0) err_addr_d = addr_q;
            if (err_count_q != CNT_MAX) err_count_d = err_count_q + (G_ADDR_SIZE + 1)'(1);
          end
          addr_d  = addr_q + G_ADDR_SIZE'(1);
          state_d = addr_last ? FINISH : RD_REQ;
        end else if (ack_expired) begin
          error_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = FINISH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      FINISH: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  a_stb_in_cyc: assert property (@(posedge clk_i) disable iff (rst_i) wb_stb_o |-> wb_cyc_o);
  a_stall_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (wb_stb_o && wb_stall_i) |=> (wb_stb_o && $stable(wb_addr_o) && $stable(wb_we_o) && $stable(wb_data_o)));

endmodule

// File: tb/tb_wb_mem_tester.sv
// Bench for wb_mem_tester: a randomised Wishbone slave plus a transaction-level model checked every cycle.
module tb_wb_mem_tester;
  localparam int A = 2;
  localparam int D = 16;
  localparam int T = 15;
  localparam int N = 1 << A;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [D-1:0] seed_i = '0;
  logic         busy_o, done_o, error_o, timeout_o;
  logic [A:0]   err_count_o;
  logic [A-1:0] err_addr_o;
  logic         wb_cyc_o, wb_stb_o, wb_we_o;
  logic         wb_stall_i = 1'b0;
  logic         wb_ack_i = 1'b0;
  logic [A-1:0] wb_addr_o;
  logic [D-1:0] wb_data_o;
  logic [D-1:0] wb_data_i = '0;

  int vectors = 0;
  int miscompares = 0;

  wb_mem_tester #(.G_ADDR_SIZE(A), .G_DATA_SIZE(D), .G_TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .seed_i(seed_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .timeout_o(timeout_o),
    .err_count_o(err_count_o), .err_addr_o(err_addr_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i),
    .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [D-1:0] pat(input logic [D-1:0] s, input int a);
    return s + D'(a);
  endfunction

  // Slave behaviour knobs.
  int stall_pct = 0;
  int ack_dmax = 1;
  bit spur = 1'b0;
  int corrupt = 0;
  bit drop2 = 1'b0;

  // Model: a run is 2N accesses (N writes then N reads); each access is a request then an ack wait.
  typedef enum int {M_IDLE, M_REQ, M_WAIT, M_FIN} mphase_t;
  mphase_t      ph = M_IDLE;
  logic [D-1:0] m_seed = '0;
  int           idx = 0, wcnt = 0, m_cnt = 0, m_eaddr = 0;
  bit           m_err = 1'b0, m_tmo = 1'b0;

  logic [D-1:0] mem [N];
  int           pend = 0, out_cnt = 0, req_no = 0;
  logic [D-1:0] pend_dat = '0;
  int           cycle_no = 0, acc1_cycle = 0, last_cyc_cycle = 0;
  bit           prev_hold = 1'b0;
  logic         prev_we = 1'b0;
  logic [A-1:0] prev_addr = '0;
  logic [D-1:0] prev_dat = '0;

  initial begin
    int a;
    bit accept;
    logic [D-1:0] d;
    forever begin
      @(negedge clk);
      cycle_no++;
      chk("busy", 32'(busy_o), 32'(ph != M_IDLE));
      chk("done", 32'(done_o), 32'(ph == M_FIN));
      chk("cyc", 32'(wb_cyc_o), 32'(ph == M_REQ || ph == M_WAIT));
      chk("stb", 32'(wb_stb_o), 32'(ph == M_REQ));
      chk("error", 32'(error_o), 32'(m_err));
      chk("timeout", 32'(timeout_o), 32'(m_tmo));
      chk("err_count", 32'(err_count_o), m_cnt);
      chk("err_addr", 32'(err_addr_o), m_eaddr);
      if (ph == M_REQ) begin
        a = idx % N;
        chk("req_we", 32'(wb_we_o), 32'(idx < N));
        chk("req_addr", 32'(wb_addr_o), a);
        chk("req_wdata", 32'(wb_data_o), 32'((idx < N) ? pat(m_seed, a) : '0));
      end
      if (prev_hold)
        chk("stall_stable", 32'({wb_stb_o, wb_we_o, wb_addr_o, wb_data_o}),
            32'({1'b1, prev_we, prev_addr, prev_dat}));
      if (wb_cyc_o) last_cyc_cycle = cycle_no;

      // Slave drive for this cycle.
      wb_ack_i  = 1'b0;
      wb_data_i = D'($urandom);
      if (rst_i) begin
        pend = 0;
        out_cnt = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          wb_ack_i  = 1'b1;
          wb_data_i = pend_dat;
          out_cnt--;
        end
      end else if (spur && (wb_stb_o || ph == M_IDLE) && $urandom_range(0, 3) == 0) begin
        wb_ack_i = 1'b1;
      end
      wb_stall_i = wb_stb_o && (int'($urandom_range(0, 99)) < stall_pct);
      accept    = wb_stb_o && !wb_stall_i && !rst_i;
      prev_hold = wb_stb_o && wb_stall_i && !rst_i;
      prev_we   = wb_we_o;
      prev_addr = wb_addr_o;
      prev_dat  = wb_data_o;
      if (accept) begin
        chk("one_outstanding", out_cnt, 0);
        if (wb_we_o) mem[wb_addr_o] = wb_data_o;
        d = mem[wb_addr_o];
        if (corrupt == 1 && wb_addr_o == 2) d = 16'hDEAD;
        if (corrupt == 2) d = ~d;
        if (corrupt == 3 && $urandom_range(0, 3) == 0) d = d ^ (16'h1 << $urandom_range(0, 15));
        out_cnt++;
        if (!(drop2 && req_no == 1)) begin
          pend = 1 + int'($urandom_range(0, ack_dmax - 1));
          pend_dat = d;
        end
        if (req_no == 1) acc1_cycle = cycle_no;
        req_no++;
      end

      // Advance the model by what the coming edge registers.
      if (rst_i) begin
        ph = M_IDLE; m_err = 0; m_tmo = 0; m_cnt = 0; m_eaddr = 0;
      end else begin
        case (ph)
          M_IDLE: if (start_i) begin
            m_seed = seed_i; idx = 0; m_err = 0; m_tmo = 0; m_cnt = 0; m_eaddr = 0;
            req_no = 0; out_cnt = 0; pend = 0; ph = M_REQ;
          end
          M_REQ: if (!wb_stall_i) begin
            wcnt = 0; ph = M_WAIT;
          end
          M_WAIT: begin
            if (wb_ack_i) begin
              if (idx >= N && wb_data_i !== pat(m_seed, idx - N)) begin
                if (m_cnt == 0) m_eaddr = idx - N;
                if (m_cnt < (1 << (A + 1)) - 1) m_cnt++;
                m_err = 1;
              end
              idx++;
              ph = (idx == 2 * N) ? M_FIN : M_REQ;
            end else begin
              wcnt++;
              if (wcnt == T) begin
                m_err = 1; m_tmo = 1; ph = M_FIN;
              end
            end
          end
          default: ph = M_IDLE;
        endcase
      end
    end
  end

  task automatic set_mode(input int st, input int dm, input bit sp, input int co, input bit dr);
    stall_pct = st; ack_dmax = dm; spur = sp; corrupt = co; drop2 = dr;
  endtask

  task automatic run_test(input logic [D-1:0] seed, input bit extra_start, output int ncyc);
    bit seen;
    seen = 1'b0;
    for (int a = 0; a < N; a++) mem[a] = ~pat(seed, a);
    repeat (2) @(posedge clk);
    #1 seed_i = seed;
    start_i = 1'b1;
    ncyc = 1;
    while (!seen && ncyc < 400) begin
      @(posedge clk);
      #1 ncyc++;
      start_i = extra_start && (ncyc == 4 || ncyc == 9);
      if (start_i) seed_i = D'($urandom);
      seen = done_o;
    end
    start_i = 1'b0;
    if (!seen) chk("run_done", 32'(done_o), 32'd1);
  endtask

  task automatic chk_mem(input string name, input logic [D-1:0] seed);
    for (int a = 0; a < N; a++) chk(name, 32'(mem[a]), 32'(pat(seed, a)));
  endtask

  initial begin
    int ncyc;
    bit found;
    logic [D-1:0] s;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_flags", 32'({busy_o, done_o, error_o, timeout_o, wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
    chk("rst_results", 32'({err_count_o, err_addr_o}), 32'd0);
    chk("rst_bus", 32'({wb_addr_o, wb_data_o}), 32'd0);

    set_mode(0, 1, 0, 0, 0);
    run_test(16'h1000, 1'b0, ncyc);
    chk("ideal_done_cycle", ncyc, 18);
    chk("ideal_mem0", 32'(mem[0]), 32'h1000);
    chk("ideal_mem3", 32'(mem[3]), 32'h1003);
    chk("ideal_result", 32'({error_o, timeout_o, err_count_o}), 32'd0);

    set_mode(0, 1, 0, 1, 0);
    run_test(16'h1000, 1'b0, ncyc);
    chk("corrupt_error", 32'(error_o), 32'd1);
    chk("corrupt_count", 32'(err_count_o), 32'd1);
    chk("corrupt_addr", 32'(err_addr_o), 32'd2);
    chk("corrupt_timeout", 32'(timeout_o), 32'd0);

    set_mode(50, 1, 1, 0, 0);
    for (int r = 0; r < 5; r++) begin
      s = (r == 0) ? 16'hFFFE : D'($urandom);
      run_test(s, 1'b0, ncyc);
      chk_mem("stall_mem", s);
      chk("stall_result", 32'({error_o, timeout_o, err_count_o}), 32'd0);
    end

    set_mode(0, 1, 0, 0, 1);
    run_test(16'h2000, 1'b0, ncyc);
    chk("tmo_cyc_span", last_cyc_cycle - acc1_cycle, T);
    chk("tmo_timeout", 32'(timeout_o), 32'd1);
    chk("tmo_error", 32'(error_o), 32'd1);
    chk("tmo_count", 32'(err_count_o), 32'd0);

    set_mode(0, 1, 0, 2, 0);
    repeat (2) @(posedge clk);
    #1 seed_i = 16'h3000;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (ph == M_WAIT && idx == N + 2) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!found) chk("rd_ack_reached", 32'(wb_cyc_o && !wb_stb_o && !wb_we_o), 32'd1);
    chk("pre_rst_count", 32'(err_count_o), 32'd2);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    chk("midrst_bus", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o}), 32'd0);
    chk("midrst_flags", 32'({busy_o, done_o, error_o, timeout_o}), 32'd0);
    chk("midrst_results", 32'({err_count_o, err_addr_o}), 32'd0);
    repeat (4) @(posedge clk);
    set_mode(0, 1, 0, 0, 0);
    run_test(16'h0042, 1'b0, ncyc);
    chk("post_rst_done_cycle", ncyc, 18);
    chk("post_rst_result", 32'({error_o, timeout_o, err_count_o}), 32'd0);

    set_mode(0, 1, 0, 2, 0);
    run_test(16'h5555, 1'b1, ncyc);
    chk("allbad_done_cycle", ncyc, 18);
    chk("allbad_count", 32'(err_count_o), 32'd4);
    chk("allbad_addr", 32'(err_addr_o), 32'd0);
    chk("allbad_error", 32'(error_o), 32'd1);

    for (int r = 0; r < 20; r++) begin
      set_mode($urandom_range(0, 60), $urandom_range(1, 3), 1'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 5) == 0);
      s = D'($urandom);
      run_test(s, 1'($urandom), ncyc);
      if (!drop2) chk_mem("rand_mem", s);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
